cva6_l2_tlb_lookup_ctrl: RTL
============================

Name: cva6_l2_tlb_lookup_ctrl

Overview:
- Sits between the L1 ITLB/DTLB miss ports and the shared L2 TLB / page-table walker (PTW).
- Arbitrates L1 misses round-robin and issues one lookup at a time to the L2 TLB.
- On an L2 hit, returns the L2 entry. On an L2 miss, launches a PTW walk and returns the walk result.
- Handles flushes by aborting lookups and squashing in-flight walk results.

Parameters:
- VADDR_W, 39, virtual address width.
- ENTRY_W, 128, opaque width of the translation entry returned to L1.
- ASID_W, 16, ASID width carried with each request.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  any TLB flush (normal/vvma/gvma OR-ed upstream)
- itlb_req_i  in  1  ITLB miss request (level-held until itlb_gnt_o)
- itlb_vaddr_i  in  VADDR_W  ITLB miss address
- itlb_gnt_o  out  1  ITLB request accepted
- dtlb_req_i  in  1  DTLB miss request (level-held until dtlb_gnt_o)
- dtlb_vaddr_i  in  VADDR_W  DTLB miss address
- dtlb_gnt_o  out  1  DTLB request accepted
- asid_i  in  ASID_W  current ASID, sampled at grant
- l2_access_o  out  1  one-cycle L2 lookup strobe
- l2_vaddr_o  out  VADDR_W  lookup address
- l2_asid_o  out  ASID_W  lookup ASID
- l2_hit_i  in  1  L2 hit, valid exactly one cycle after l2_access_o
- l2_entry_i  in  ENTRY_W  L2 entry, qualified by l2_hit_i
- l2_flushing_i  in  1  L2 TLB busy flushing
- ptw_req_o  out  1  walk request (held until ptw_ack_i)
- ptw_vaddr_o  out  VADDR_W  walk address
- ptw_ack_i  in  1  PTW accepted the walk
- ptw_done_i  in  1  walk complete, one-cycle pulse
- ptw_entry_i  in  ENTRY_W  walk result
- ptw_err_i  in  1  walk faulted
- resp_valid_o  out  1  one-cycle response pulse
- resp_is_d_o  out  1  1 = response is for the DTLB, 0 = ITLB
- resp_entry_o  out  ENTRY_W  translation entry
- resp_err_o  out  1  page fault
- resp_from_l2_o  out  1  1 = entry came from the L2 TLB
- busy_o  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0; FSM = IDLE; round-robin pointer = I (DTLB wins first contention); kill flag = 0.
- FSM states: IDLE, LOOKUP, WAIT_WALK_ACK, WALK, RESP.
- IDLE:
  - If flush_i or l2_flushing_i is high, issue no grant.
  - Otherwise, if any request is pending, grant one requester with round-robin between I and D. The pointer flips to the other requester after each grant.
  - In the grant cycle: assert *_gnt_o, latch vaddr, asid_i and the requester ID, assert l2_access_o with l2_vaddr_o/l2_asid_o taken combinationally from the granted input, then go to LOOKUP.
- LOOKUP (the cycle after access):
  - flush_i → IDLE, no response.
  - Else l2_hit_i → latch l2_entry_i, set from_l2 = 1, err = 0, go to RESP.
  - Else → go to WAIT_WALK_ACK.
- WAIT_WALK_ACK:
  - ptw_req_o = 1 and ptw_vaddr_o = latched vaddr.
  - ptw_ack_i → WALK.
  - flush_i before the ack → drop ptw_req_o, go to IDLE.
- WALK:
  - flush_i sets the kill flag.
  - On ptw_done_i: if kill (or flush_i in the same cycle), go to IDLE with no response and clear kill. Otherwise latch ptw_entry_i and ptw_err_i, set from_l2 = 0, go to RESP.
- RESP:
  - resp_valid_o = 1 for exactly one cycle, with the registered entry, error, source and requester ID. Then go to IDLE.
  - flush_i in RESP does not suppress the response, because it was already committed.
- Latency:
  - L2 hit: grant to resp_valid_o is 2 cycles.
  - Miss: resp_valid_o follows ptw_done_i by one cycle.
- Only one outstanding request at a time. No grant is issued in any state other than IDLE.
- A requester that drops its request before being granted is simply not serviced.
- Reset asserted mid-operation returns to IDLE on the next edge. No response is emitted and ptw_req_o is deasserted.
- When an error response is returned, resp_entry_o is don't-care.

Decomposition:
- Shared MMU package holds:
  - the FSM state enum l2_lookup_state_e;
  - the requester ID type (I/D);
  - a response struct l2_lookup_resp_t containing entry, err, from_l2 and is_d.
- One natural sub-module: cva6_rr_arb2, a 2-input round-robin arbiter with grant-gated pointer update. Everything else stays flat.

Test Plan:
- L2 hit: dtlb_req_i with vaddr 0x40_0000_1000, l2_hit_i = 1 in the next cycle with entry 0xABCD → dtlb_gnt_o at t0, l2_access_o at t0, resp_valid_o at t2 with resp_is_d_o = 1, resp_from_l2_o = 1, entry 0xABCD.
- L2 miss: itlb_req_i with 0x1000, l2_hit_i = 0, ptw_ack_i 3 cycles later, ptw_done_i 10 cycles later with entry 0x55 → ptw_req_o is held until ack; resp_valid_o comes one cycle after done with resp_from_l2_o = 0, resp_is_d_o = 0.
- Contention: itlb_req_i and dtlb_req_i held together from reset → grants in the order D, I, D; each grant occurs only after the previous resp_valid_o.
- Flush during WALK: flush_i pulses between ptw_ack_i and ptw_done_i → no resp_valid_o; FSM returns to IDLE; the next request is serviced normally.
- l2_flushing_i held high with requests pending → no *_gnt_o and no l2_access_o until it drops; the grant follows in the first cycle after it drops.
- Walk fault: ptw_err_i = 1 with ptw_done_i → resp_err_o = 1 with resp_valid_o.
- Reset in WAIT_WALK_ACK: ptw_req_o = 0 and busy_o = 0 on the next cycle.

Source files
------------

// File: rtl/cva6_l2_tlb_lookup_ctrl_pkg.sv
// Shared MMU types for the L2 TLB lookup controller: FSM states, requester ID
// and the registered response bundle.
package cva6_l2_tlb_lookup_ctrl_pkg;

  localparam int unsigned L2_ENTRY_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_WALK_ACK,
    WALK,
    RESP
  } l2_lookup_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } l2_req_id_e;

  typedef struct packed {
    logic [L2_ENTRY_W-1:0] entry;
    logic                  err;
    logic                  from_l2;
    logic                  is_d;
  } l2_lookup_resp_t;

endpackage

// File: rtl/cva6_rr_arb2.sv
// Two-way round-robin arbiter. The last-granted pointer only moves on a real
// grant, so gated-off cycles never skew fairness.
module cva6_rr_arb2
  import cva6_l2_tlb_lookup_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output l2_req_id_e gnt_id
);

  l2_req_id_e last;

  always_comb begin
    gnt_id = REQ_I;
    // D wins if it is alone, or on contention when I was served last
    if (req[1] && (!req[0] || last == REQ_I)) gnt_id = REQ_D;
    gnt[1] = en && req[1] && (gnt_id == REQ_D);
    gnt[0] = en && req[0] && (gnt_id == REQ_I);
  end

  always_ff @(posedge clk) begin
    if (rst)       last <= REQ_I;
    else if (|gnt) last <= gnt_id;
  end

endmodule

// File: rtl/cva6_l2_tlb_lookup_ctrl.sv
// Serialises L1 ITLB/DTLB misses onto the shared L2 TLB, falls back to the
// PTW on an L2 miss, and squashes work on flush.
module cva6_l2_tlb_lookup_ctrl
  import cva6_l2_tlb_lookup_ctrl_pkg::*;
#(
  parameter int unsigned VADDR_W = 39,
  parameter int unsigned ENTRY_W = L2_ENTRY_W,
  parameter int unsigned ASID_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               itlb_req_i,
  input  logic [VADDR_W-1:0] itlb_vaddr_i,
  output logic               itlb_gnt_o,
  input  logic               dtlb_req_i,
  input  logic [VADDR_W-1:0] dtlb_vaddr_i,
  output logic               dtlb_gnt_o,
  input  logic [ASID_W-1:0]  asid_i,
  output logic               l2_access_o,
  output logic [VADDR_W-1:0] l2_vaddr_o,
  output logic [ASID_W-1:0]  l2_asid_o,
  input  logic               l2_hit_i,
  input  logic [ENTRY_W-1:0] l2_entry_i,
  input  logic               l2_flushing_i,
  output logic               ptw_req_o,
  output logic [VADDR_W-1:0] ptw_vaddr_o,
  input  logic               ptw_ack_i,
  input  logic               ptw_done_i,
  input  logic [ENTRY_W-1:0] ptw_entry_i,
  input  logic               ptw_err_i,
  output logic               resp_valid_o,
  output logic               resp_is_d_o,
  output logic [ENTRY_W-1:0] resp_entry_o,
  output logic               resp_err_o,
  output logic               resp_from_l2_o,
  output logic               busy_o
);

  l2_lookup_state_e state, state_next;
  l2_lookup_resp_t  resp_q;
  l2_req_id_e       id_q, arb_id;
  logic [VADDR_W-1:0] vaddr_q, gnt_vaddr;
  logic [1:0]       arb_gnt;
  logic             granted, kill;

  cva6_rr_arb2 u_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    ({dtlb_req_i, itlb_req_i}),
    .en     (state == IDLE && !flush_i && !l2_flushing_i),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  assign granted   = |arb_gnt;
  assign gnt_vaddr = (arb_id == REQ_D) ? dtlb_vaddr_i : itlb_vaddr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (granted) state_next = LOOKUP;
      LOOKUP:        if (flush_i)       state_next = IDLE;
                     else if (l2_hit_i) state_next = RESP;
                     else               state_next = WAIT_WALK_ACK;
      // An ack racing a flush means the PTW owns a walk; follow it and kill the result
      WAIT_WALK_ACK: if (ptw_ack_i)    state_next = WALK;
                     else if (flush_i) state_next = IDLE;
      WALK:          if (ptw_done_i) state_next = (kill || flush_i) ? IDLE : RESP;
      RESP:          state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_comb begin
    itlb_gnt_o     = arb_gnt[0];
    dtlb_gnt_o     = arb_gnt[1];
    l2_access_o    = granted;
    l2_vaddr_o     = granted ? gnt_vaddr : '0;
    l2_asid_o      = granted ? asid_i : '0;
    ptw_req_o      = (state == WAIT_WALK_ACK);
    ptw_vaddr_o    = (state == WAIT_WALK_ACK) ? vaddr_q : '0;
    resp_valid_o   = (state == RESP);
    resp_is_d_o    = resp_valid_o && resp_q.is_d;
    resp_err_o     = resp_valid_o && resp_q.err;
    resp_from_l2_o = resp_valid_o && resp_q.from_l2;
    resp_entry_o   = resp_valid_o ? resp_q.entry[ENTRY_W-1:0] : '0;
    busy_o         = (state != IDLE);
  end

  // The ASID only matters on the lookup strobe, so it is not kept afterwards
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vaddr_q <= '0;
      id_q    <= REQ_I;
      resp_q  <= '0;
      kill    <= 1'b0;
    end else begin
      if (granted) begin
        vaddr_q <= gnt_vaddr;
        id_q    <= arb_id;
      end
      if (state == LOOKUP && !flush_i && l2_hit_i)
        resp_q <= '{entry: L2_ENTRY_W'(l2_entry_i), err: 1'b0, from_l2: 1'b1,
                    is_d: (id_q == REQ_D)};
      if (state == WALK && ptw_done_i && !kill && !flush_i)
        resp_q <= '{entry: L2_ENTRY_W'(ptw_entry_i), err: ptw_err_i, from_l2: 1'b0,
                    is_d: (id_q == REQ_D)};
      if (state == WAIT_WALK_ACK && ptw_ack_i && flush_i)
        kill <= 1'b1;
      else if (state == WALK) begin
        if (ptw_done_i)   kill <= 1'b0;
        else if (flush_i) kill <= 1'b1;
      end
    end
  end

endmodule
